// File: rtl/regfile_pkg.sv
// Shared parameters and types for the register-file pending-write scoreboard.
package regfile_pkg;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned PEND_W   = 2;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [PEND_W-1:0]   pend_t;

    localparam pend_t   PEND_MAX = pend_t'(3);
    localparam reg_id_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard_pend.sv
// Per-register pending-write counter: saturating up/down with synchronous clear.
module pend_counter
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  dec,
    input  logic  clr,
    output pend_t cnt,
    output logic  nz
);
    pend_t r_cnt;

    // Simultaneous inc and dec cancel out and leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !dec && (r_cnt != PEND_MAX)) begin
            r_cnt <= r_cnt + pend_t'(1);
        end else if (dec && !inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - pend_t'(1);
        end
    end

    assign cnt = r_cnt;
    assign nz  = (r_cnt != '0);
endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard and issue gate for the 16-entry register file; R0 is never tracked.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  reg_id_t             iss_src1,
    input  reg_id_t             iss_src2,
    input  logic                iss_use1,
    input  logic                iss_use2,
    input  reg_id_t             iss_dst,
    input  logic                iss_wr,
    output logic                iss_ready,
    input  logic                wb_valid,
    input  reg_id_t             wb_dst,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy,
    output logic [15:0]         stall_cycles
);
    pend_t               w_pend [NUM_REGS];
    pend_t               w_eff  [NUM_REGS];
    logic [NUM_REGS-1:0] w_nz;
    logic [NUM_REGS-1:0] w_wb_hit;
    logic                w_fire;
    logic                w_src1_haz;
    logic                w_src2_haz;
    logic                w_dst_haz;
    logic [15:0]         r_stall;

    assign w_pend[0] = '0;
    assign w_nz[0]   = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_pend
            pend_counter u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (w_fire && iss_wr && (iss_dst == reg_id_t'(g))),
                .dec (w_wb_hit[g] && !flush),
                .clr (flush),
                .cnt (w_pend[g]),
                .nz  (w_nz[g])
            );
        end
    endgenerate

    // A writeback presented this cycle already resolves the hazard for issue.
    always_comb begin
        w_wb_hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_wb_hit[i] = wb_valid && (i != 0) && (wb_dst == reg_id_t'(i)) && (w_pend[i] != '0);
            w_eff[i]    = w_pend[i] - pend_t'(w_wb_hit[i]);
        end
    end

    always_comb begin
        w_src1_haz = iss_use1 && (iss_src1 != ZERO_REG) && (w_eff[iss_src1] != '0);
        w_src2_haz = iss_use2 && (iss_src2 != ZERO_REG) && (w_eff[iss_src2] != '0);
        w_dst_haz  = iss_wr && (iss_dst != ZERO_REG) && (w_eff[iss_dst] == PEND_MAX);
        iss_ready  = !flush && !w_src1_haz && !w_src2_haz && !w_dst_haz;
        w_fire     = iss_valid && iss_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (iss_valid && !iss_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign busy         = w_nz;
    assign stall_cycles = r_stall;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios then random traffic against a behavioural scoreboard model.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_use1, iss_use2, iss_wr, wb_valid, flush;
    logic [3:0]  iss_src1, iss_src2, iss_dst, wb_dst;
    logic        iss_ready;
    logic [15:0] busy;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    int m_pend [16];
    int m_stall;

    regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_src1     (iss_src1),
        .iss_src2     (iss_src2),
        .iss_use1     (iss_use1),
        .iss_use2     (iss_use2),
        .iss_dst      (iss_dst),
        .iss_wr       (iss_wr),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .flush        (flush),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int r);
        int hit;
        hit = (wb_valid && r != 0 && int'(wb_dst) == r && m_pend[r] > 0) ? 1 : 0;
        return m_pend[r] - hit;
    endfunction

    function automatic bit model_ready();
        bit ok;
        ok = !flush;
        if (iss_use1 && iss_src1 != 0 && eff(int'(iss_src1)) != 0) ok = 0;
        if (iss_use2 && iss_src2 != 0 && eff(int'(iss_src2)) != 0) ok = 0;
        if (iss_wr && iss_dst != 0 && eff(int'(iss_dst)) == 3) ok = 0;
        return ok;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        b = '0;
        for (int i = 1; i < 16; i++) b[i] = (m_pend[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_stall = 0;
    endtask

    // Drive one cycle of inputs, check the combinational ready, clock, then check registered state.
    task automatic step(input string tag, input bit v, input int s1, input int s2, input bit u1,
                        input bit u2, input int d, input bit w, input bit wv, input int wd, input bit fl);
        bit exp_rdy;
        int wb_r;
        iss_valid = v; iss_src1 = 4'(s1); iss_src2 = 4'(s2); iss_use1 = u1; iss_use2 = u2;
        iss_dst = 4'(d); iss_wr = w; wb_valid = wv; wb_dst = 4'(wd); flush = fl;
        #1;
        exp_rdy = model_ready();
        chk({tag, ".ready"}, 32'(iss_ready), 32'(exp_rdy));
        wb_r = -1;
        if (wv && wd != 0 && m_pend[wd] > 0) wb_r = wd;
        @(posedge clk);
        if (v && !exp_rdy && m_stall < 65535) m_stall++;
        if (fl) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
        end else begin
            if (wb_r > 0) m_pend[wb_r]--;
            if (v && exp_rdy && w && d != 0) m_pend[d]++;
        end
        #1;
        chk({tag, ".busy"}, 32'(busy), 32'(model_busy()));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
    endtask

    initial begin
        rst = 1'b1;
        iss_valid = 0; iss_use1 = 0; iss_use2 = 0; iss_wr = 0; wb_valid = 0; flush = 0;
        iss_src1 = 0; iss_src2 = 0; iss_dst = 0; wb_dst = 0;
        model_reset();
        #2;
        chk("reset.busy", 32'(busy), 32'h0);
        chk("reset.stall", 32'(stall_cycles), 32'h0);
        chk("reset.ready", 32'(iss_ready), 32'h1);
        #9 rst = 1'b0;

        // basic issue to R5
        step("iss5", 1, 3, 4, 1, 1, 5, 1, 0, 0, 0);
        chk("iss5.busy_const", 32'(busy), 32'h0020);

        // dependent on R5 stalls until writeback presented
        step("dep5a", 1, 5, 0, 1, 0, 6, 0, 0, 0, 0);
        chk("dep5a.ready_const", 32'(iss_ready), 32'h0);
        step("dep5b", 1, 5, 0, 1, 0, 6, 0, 0, 0, 0);
        chk("dep5b.stall_const", 32'(stall_cycles), 32'd2);
        step("dep5wb", 1, 5, 0, 1, 0, 6, 0, 1, 5, 0);
        chk("dep5wb.busy_const", 32'(busy), 32'h0000);

        // R7 saturation with same-cycle writeback
        step("r7a", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("r7b", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("r7c", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("r7full", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("r7wb", 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        chk("r7wb.pend", 32'(dut.g_pend[7].u_cnt.cnt), 32'd3);

        // fill all registers, then R0 traffic
        for (int r = 1; r < 16; r++) step("fill", 1, 0, 0, 0, 0, r, 1, 0, 0, 0);
        step("r0iss", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step("r0wb", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("r0.busy_const", 32'(busy), 32'hFFFE);

        // flush with issue pending
        step("fl", 1, 0, 0, 0, 0, 2, 1, 1, 9, 1);
        chk("fl.busy_const", 32'(busy), 32'h0000);
        step("pfl_wb9", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

        // asynchronous reset mid-stall
        step("ms_iss", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step("ms_stall", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst.busy", 32'(busy), 32'h0);
        chk("arst.stall", 32'(stall_cycles), 32'h0);
        chk("arst.ready", 32'(iss_ready), 32'h1);
        #2 rst = 1'b0;

        // random traffic, registers biased to a small set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            int s1, s2, d, wd;
            s1 = int'($urandom_range(0, 5));
            s2 = int'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 5));
            wd = int'($urandom_range(0, 5));
            step("rnd", 1'($urandom_range(0, 3) != 0), s1, s2, 1'($urandom), 1'($urandom),
                 d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), wd,
                 1'($urandom_range(0, 40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
